sample_iterator: RTL and testbench

Transmitter side of the rasterizer sample stream. Accepts one triangle plus its subsample-aligned bounding box from the bounding-box stage. Walks every subsample location in the box in row-major order, emitting one sample per cycle together with the triangle and color. The emitted stream is the sample/triangle/valid stream consumed by the sample-test stage (via the jitter stage), and upstream is stalled while iteration is in progress.

---
 rtl/sample_iterator_pkg.sv | 31 +++
 rtl/sample_iterator_advance.sv | 42 ++++
 rtl/sample_iterator.sv | 107 ++++++++++
 tb/tb_sample_iterator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_iterator_pkg.sv
// Shared raster definitions for the sample iterator: FSM states,
// subsample-rate codes and the subsample step computation.
package sample_iterator_pkg;

   // Iterator state; WAIT_STATE is the only state that accepts a triangle.
   typedef enum logic {
      WAIT_STATE = 1'b0,
      TEST_STATE = 1'b1
   } state_t;

   // One-hot subsample rate codes (samples per pixel).
   localparam logic [3:0] SUB_1  = 4'b1000;
   localparam logic [3:0] SUB_4  = 4'b0100;
   localparam logic [3:0] SUB_16 = 4'b0010;
   localparam logic [3:0] SUB_64 = 4'b0001;

   // Distance between neighbouring subsamples in fixed point.
   // Unknown codes fall back to one sample per pixel.
   function automatic logic [31:0] step_size(input logic [3:0] code, input int unsigned radix);
      logic [31:0] one;
      one = 32'd1;
      case (code)
         SUB_1:   return one << radix;
         SUB_4:   return one << (radix - 1);
         SUB_16:  return one << (radix - 2);
         SUB_64:  return one << (radix - 3);
         default: return one << radix;
      endcase
   endfunction

endpackage

// File: rtl/sample_iterator_advance.sv
// Combinational row-major step through the bounding box. Sums are formed
// one bit wider than the operands so a step past the most positive
// coordinate compares as "beyond the box" instead of wrapping negative.
module sample_advance #(
   parameter int SIGFIG = 24
) (
   input  logic signed [SIGFIG-1:0] sample [2],
   input  logic signed [SIGFIG-1:0] ll_x,
   input  logic signed [SIGFIG-1:0] ur [2],
   input  logic        [SIGFIG-1:0] step,
   output logic signed [SIGFIG-1:0] next_sample [2],
   output logic                     row_wrap,
   output logic                     done
);

   logic signed [SIGFIG:0] sx, sy, ux, uy, st, nx, ny;

   // Choose between next column, first column of the next row, or end of box.
   always_comb begin
      sx = {sample[0][SIGFIG-1], sample[0]};
      sy = {sample[1][SIGFIG-1], sample[1]};
      ux = {ur[0][SIGFIG-1], ur[0]};
      uy = {ur[1][SIGFIG-1], ur[1]};
      st = {1'b0, step};
      nx = sx + st;
      ny = sy + st;
      next_sample[0] = sample[0];
      next_sample[1] = sample[1];
      row_wrap       = 1'b0;
      done           = 1'b0;
      if (nx <= ux) begin
         next_sample[0] = nx[SIGFIG-1:0];
      end else if (ny <= uy) begin
         next_sample[0] = ll_x;
         next_sample[1] = ny[SIGFIG-1:0];
         row_wrap       = 1'b1;
      end else begin
         done = 1'b1;
      end
   end

endmodule

// File: rtl/sample_iterator.sv
// Sample iterator: accepts a triangle and its subsample-aligned box, then
// emits every subsample location in row-major order, one per cycle.
//
// Handshake: upstream presents validTri_R13H with tri/color/box/rate and
// holds them stable while halt_RnnnnL=0. A triangle is taken in any cycle
// where halt_RnnnnL=1 and validTri_R13H=1 (an inverted box is consumed
// and dropped). Downstream has no backpressure: validSamp_R14H=1 marks
// sample_R14S as a real sample for exactly that cycle.
module sample_iterator
   import sample_iterator_pkg::*;
#(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S [2][2],
   input  logic                     validTri_R13H,
   input  logic        [3:0]        subSample_RnnnnU,
   output logic                     halt_RnnnnL,
   output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R14U [COLORS],
   output logic signed [SIGFIG-1:0] sample_R14S [2],
   output logic                     validSamp_R14H
);

   state_t                  state, next_state;
   logic signed [SIGFIG-1:0] ll_x_q;
   logic signed [SIGFIG-1:0] ur_q [2];
   logic        [SIGFIG-1:0] step_q;
   logic                     box_ok, accept;
   logic signed [SIGFIG-1:0] adv_sample [2];
   logic                     adv_wrap, adv_done;

   assign box_ok      = (box_R13S[0][0] <= box_R13S[1][0]) &&
                        (box_R13S[0][1] <= box_R13S[1][1]);
   assign accept      = (state == WAIT_STATE) && validTri_R13H && box_ok;
   assign halt_RnnnnL = (state == WAIT_STATE);

   sample_advance #(.SIGFIG(SIGFIG)) u_advance (
      .sample      (sample_R14S),
      .ll_x        (ll_x_q),
      .ur          (ur_q),
      .step        (step_q),
      .next_sample (adv_sample),
      .row_wrap    (adv_wrap),
      .done        (adv_done)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_STATE;
      else     state <= next_state;
   end

   // Next state: enter TEST on a good triangle, leave when the box is exhausted.
   always_comb begin
      next_state = state;
      case (state)
         WAIT_STATE: if (accept)   next_state = TEST_STATE;
         TEST_STATE: if (adv_done) next_state = WAIT_STATE;
         default:                  next_state = WAIT_STATE;
      endcase
   end

   // Latch triangle data on acceptance and step the sample while iterating.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
               tri_R14S[v][a] <= '0;
         for (int c = 0; c < COLORS; c++)
            color_R14U[c] <= '0;
         sample_R14S[0] <= '0;
         sample_R14S[1] <= '0;
         ll_x_q         <= '0;
         ur_q[0]        <= '0;
         ur_q[1]        <= '0;
         step_q         <= '0;
         validSamp_R14H <= 1'b0;
      end else if (accept) begin
         tri_R14S       <= tri_R13S;
         color_R14U     <= color_R13U;
         sample_R14S[0] <= box_R13S[0][0];
         sample_R14S[1] <= box_R13S[0][1];
         ll_x_q         <= box_R13S[0][0];
         ur_q[0]        <= box_R13S[1][0];
         ur_q[1]        <= box_R13S[1][1];
         step_q         <= SIGFIG'(step_size(subSample_RnnnnU, RADIX));
         validSamp_R14H <= 1'b1;
      end else if (state == TEST_STATE) begin
         if (adv_done) begin
            validSamp_R14H <= 1'b0;
         end else begin
            // x moves every cycle; y only changes on a row wrap.
            sample_R14S[0] <= adv_sample[0];
            if (adv_wrap) sample_R14S[1] <= adv_sample[1];
         end
      end
   end

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: expected sample locations are
// queued when a triangle is driven and compared as the DUT emits them.
module tb_sample_iterator;

  localparam int W = 24;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] tri_R13S [3][3];
  logic        [W-1:0] color_R13U [3];
  logic signed [W-1:0] box_R13S [2][2];
  logic                validTri_R13H;
  logic        [3:0]   subSample_RnnnnU;
  logic                halt_RnnnnL;
  logic signed [W-1:0] tri_R14S [3][3];
  logic        [W-1:0] color_R14U [3];
  logic signed [W-1:0] sample_R14S [2];
  logic                validSamp_R14H;

  logic [2*W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic signed [W-1:0] exp_tri [3][3];
  logic        [W-1:0] exp_color [3];

  sample_iterator dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // scoreboard: every valid sample must match the head of the expected queue
  always @(negedge clk) begin
    if (validSamp_R14H === 1'b1) begin
      logic [2*W-1:0] act;
      act = {sample_R14S[0], sample_R14S[1]};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample got (%0d,%0d) expected none",
                 $signed(sample_R14S[0]), $signed(sample_R14S[1]));
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sample got (%0d,%0d) expected (%0d,%0d)",
                   $signed(act[2*W-1:W]), $signed(act[W-1:0]),
                   $signed(e[2*W-1:W]), $signed(e[W-1:0]));
        end
      end
    end
  end

  // reference walk of the box in row-major order
  task automatic push_expected(input int llx, input int lly, input int urx, input int ury,
                               input logic [3:0] code);
    int step;
    case (code)
      4'b1000: step = 1024;
      4'b0100: step = 512;
      4'b0010: step = 256;
      4'b0001: step = 128;
      default: step = 1024;
    endcase
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step)
        exp_q.push_back({W'(x), W'(y)});
  endtask

  // drive one triangle; returns at #1 after the accepting edge (cycle 1)
  task automatic drive_tri(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] code, input bit push);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) begin
        tri_R13S[v][a] = W'($urandom_range(0, 32'hFFFFFF));
        exp_tri[v][a]  = tri_R13S[v][a];
      end
    for (int c = 0; c < 3; c++) begin
      color_R13U[c] = W'($urandom_range(0, 32'hFFFFFF));
      exp_color[c]  = color_R13U[c];
    end
    box_R13S[0][0] = W'(llx);
    box_R13S[0][1] = W'(lly);
    box_R13S[1][0] = W'(urx);
    box_R13S[1][1] = W'(ury);
    subSample_RnnnnU = code;
    validTri_R13H = 1'b1;
    if (push) push_expected(llx, lly, urx, ury, code);
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
  endtask

  // check n sample cycles with halt low, then the bubble cycle
  task automatic expect_iter(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (halt_RnnnnL !== 1'b0 || validSamp_R14H !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy cycle %0d got halt=%b valid=%b expected halt=0 valid=1",
                 name, i + 1, halt_RnnnnL, validSamp_R14H);
      end
    end
    @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1 || validSamp_R14H !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_end got halt=%b valid=%b pending=%0d expected halt=1 valid=0 pending=0",
               name, halt_RnnnnL, validSamp_R14H, exp_q.size());
    end
    checks++;
    if (tri_R14S !== exp_tri || color_R14U !== exp_color) begin
      errors++;
      $display("FAIL %s_latch got tri00=%0h color0=%0h expected tri00=%0h color0=%0h",
               name, tri_R14S[0][0], color_R14U[0], exp_tri[0][0], exp_color[0]);
    end
  endtask

  task automatic check_idle_zero(input string name);
    @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1 || validSamp_R14H !== 1'b0 ||
        sample_R14S[0] !== '0 || sample_R14S[1] !== '0 ||
        tri_R14S[0][0] !== '0 || tri_R14S[2][2] !== '0 || color_R14U[1] !== '0) begin
      errors++;
      $display("FAIL %s got halt=%b valid=%b sample=(%0d,%0d) tri00=%0h color1=%0h expected halt=1 valid=0 zeros",
               name, halt_RnnnnL, validSamp_R14H, $signed(sample_R14S[0]),
               $signed(sample_R14S[1]), tri_R14S[0][0], color_R14U[1]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    validTri_R13H = 1'b0;
    subSample_RnnnnU = 4'b1000;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++) tri_R13S[v][a] = '0;
    for (int c = 0; c < 3; c++) color_R13U[c] = '0;
    for (int b = 0; b < 2; b++) begin
      box_R13S[b][0] = '0;
      box_R13S[b][1] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_zero("reset");
  endtask

  task automatic test_rate1();
    drive_tri(0, 0, 2048, 1024, 4'b1000, 1'b1);
    expect_iter("rate1", 6);
  endtask

  task automatic test_single();
    drive_tri(512, 512, 512, 512, 4'b0100, 1'b1);
    expect_iter("single", 1);
  endtask

  task automatic test_drop();
    drive_tri(1024, 0, 0, 0, 4'b1000, 1'b1);
    @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1 || validSamp_R14H !== 1'b0) begin
      errors++;
      $display("FAIL drop got halt=%b valid=%b expected halt=1 valid=0",
               halt_RnnnnL, validSamp_R14H);
    end
    drive_tri(0, 0, 1024, 0, 4'b1000, 1'b1);
    expect_iter("after_drop", 2);
  endtask

  task automatic test_signed();
    drive_tri(-512, -512, -256, -512, 4'b0010, 1'b1);
    expect_iter("signed", 2);
  endtask

  task automatic test_top_edge();
    // stepping past the largest coordinate must end the box, not wrap
    drive_tri(8388607 - 100, 8388607 - 100, 8388607, 8388607, 4'b1000, 1'b1);
    expect_iter("top_edge", 1);
    drive_tri(0, 0, 384, 128, 4'b0001, 1'b1);
    expect_iter("rate64", 8);
  endtask

  task automatic test_hold();
    logic signed [W-1:0] a_tri00;
    drive_tri(0, 0, 2048, 1024, 4'b1000, 1'b1);
    a_tri00 = exp_tri[0][0];
    @(negedge clk);
    @(posedge clk); #1;
    // new triangle presented mid-iteration, with a different rate
    tri_R13S[0][0] = ~a_tri00;
    box_R13S[0][0] = W'(0);
    box_R13S[0][1] = W'(0);
    box_R13S[1][0] = W'(128);
    box_R13S[1][1] = W'(0);
    subSample_RnnnnU = 4'b0001;
    validTri_R13H = 1'b1;
    push_expected(0, 0, 128, 0, 4'b0001);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (halt_RnnnnL !== 1'b0 || tri_R14S[0][0] !== a_tri00) begin
        errors++;
        $display("FAIL hold cycle %0d got halt=%b tri00=%0h expected halt=0 tri00=%0h",
                 i, halt_RnnnnL, tri_R14S[0][0], a_tri00);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (halt_RnnnnL !== 1'b1 || validSamp_R14H !== 1'b0) begin
      errors++;
      $display("FAIL hold_bubble got halt=%b valid=%b expected halt=1 valid=0",
               halt_RnnnnL, validSamp_R14H);
    end
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    exp_tri[0][0] = ~a_tri00;
    expect_iter("held_tri", 2);
  endtask

  task automatic test_mid_reset();
    drive_tri(0, 0, 2048, 1024, 4'b1000, 1'b0);
    push_expected(0, 0, 2048, 0, 4'b1000);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("mid_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_pending got %0d expected 0", exp_q.size());
    end
    drive_tri(1024, 1024, 2048, 2048, 4'b1000, 1'b1);
    expect_iter("after_reset", 4);
  endtask

  initial begin
    test_reset();
    test_rate1();
    test_single();
    test_drop();
    test_signed();
    test_top_edge();
    test_hold();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
